// File: rtl/pzbcm_rle_expander.sv
// Run-length expander: takes {data, count} entries and emits each data word count times.
// A single held entry drives the output registers directly; a zero-count entry is consumed silently.
module pzbcm_rle_expander #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_last,
  output logic [COUNT_WIDTH-1:0] o_remaining
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t                 state;
  logic                   hold_valid;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic [COUNT_WIDTH-1:0] hold_remaining;

  logic accept;
  logic transfer;
  logic load;

  assign hold_valid = (state == EXPAND);

  assign o_valid     = hold_valid;
  assign o_data      = hold_data;
  assign o_remaining = hold_remaining;
  assign o_last      = hold_valid && (hold_remaining == COUNT_WIDTH'(1));

  // A new entry may enter while the last copy of the current one leaves.
  assign o_ready  = !i_clear && (!hold_valid || (i_ready && o_last));
  assign accept   = i_valid && o_ready;
  assign transfer = o_valid && i_ready;
  assign load     = accept && (i_count != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      hold_remaining <= '0;
    end else if (i_clear) begin
      state          <= IDLE;
      hold_remaining <= '0;
    end else if (load) begin
      state          <= EXPAND;
      hold_remaining <= i_count;
    end else if (transfer) begin
      // A transfer only happens while holding, so remaining is at least 1 here.
      hold_remaining <= hold_remaining - COUNT_WIDTH'(1);
      if (o_last) begin
        state <= IDLE;
      end
    end
  end

  // NOTE: the data register carries no reset; it is only observed while hold_valid is set.
  always_ff @(posedge i_clk) begin
    if (load && !i_rst) begin
      hold_data <= i_data;
    end
  end

endmodule

// File: tb/tb_pzbcm_rle_expander.sv
// Directed bench for pzbcm_rle_expander: a queue-of-words model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pzbcm_rle_expander;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          i_rst;
  logic          i_clear;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_count;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [CW-1:0] o_remaining;

  pzbcm_rle_expander #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_count     (i_count),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_remaining (o_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output stream: one element per word still owed to downstream.
  typedef struct {
    logic [DW-1:0] data;
    int            rem;
  } word_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } xfer_t;

  word_t exp_q[$];
  xfer_t log_q[$];
  bit    model_on = 0;

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !i_clear && (exp_q.size() == 0 || (i_ready && exp_q.size() == 1));
    if (model_on) begin
      check("o_valid", o_valid, exp_valid);
      check("o_ready", o_ready, exp_ready);
      if (exp_valid) begin
        check("o_data", o_data, exp_q[0].data);
        check("o_remaining", o_remaining, exp_q[0].rem);
        check("o_last", o_last, exp_q[0].rem == 1);
      end else begin
        check("o_remaining_idle", o_remaining, 0);
        check("o_last_idle", o_last, 0);
      end
    end
    if (!i_rst && !i_clear && o_valid === 1'b1 && i_ready === 1'b1)
      log_q.push_back('{data: o_data, last: o_last});
    if (i_rst || i_clear) begin
      exp_q.delete();
      if (i_rst) model_on = 1;
    end else if (model_on) begin
      if (exp_valid && i_ready) void'(exp_q.pop_front());
      if (i_valid && exp_ready && i_count != 0)
        for (int k = int'(i_count); k >= 1; k--) exp_q.push_back('{data: i_data, rem: k});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_data(input int from, input logic [DW-1:0] d);
    int n = 0;
    for (int i = from; i < log_q.size(); i++) if (log_q[i].data == d) n++;
    return n;
  endfunction

  function automatic int count_last(input int from);
    int n = 0;
    for (int i = from; i < log_q.size(); i++) if (log_q[i].last) n++;
    return n;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_valid === 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", o_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int mark;
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_count = '0;
    step(); step();
    i_rst = 1'b0;
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_remaining", o_remaining, 0);
    check("rst_o_ready", o_ready, 1);

    // Single entry, count 3
    i_ready = 1'b1;
    i_valid = 1'b1; i_data = 8'hA5; i_count = 4'd3;
    step();
    i_valid = 1'b0;
    #1;
    check("s1_c1_valid", o_valid, 1); check("s1_c1_data", o_data, 8'hA5);
    check("s1_c1_rem", o_remaining, 3); check("s1_c1_last", o_last, 0);
    check("s1_c1_ready", o_ready, 0);
    step();
    check("s1_c2_rem", o_remaining, 2); check("s1_c2_last", o_last, 0);
    check("s1_c2_ready", o_ready, 0);
    step();
    check("s1_c3_rem", o_remaining, 1); check("s1_c3_last", o_last, 1);
    check("s1_c3_data", o_data, 8'hA5);
    step();
    check("s1_done_valid", o_valid, 0);

    // Back-to-back count-1 entries, no bubbles
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = DW'(i + 1); i_count = 4'd1;
      step();
      check("b2b_valid", o_valid, 1);
      check("b2b_data", o_data, i + 1);
      check("b2b_last", o_last, 1);
    end
    i_valid = 1'b0;
    step();
    check("b2b_done_valid", o_valid, 0);

    // Backpressure
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h3C; i_count = 4'd2;
    step();
    i_valid = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", o_valid, 1); check("bp_data", o_data, 8'h3C);
      check("bp_rem", o_remaining, 2); check("bp_ready", o_ready, 0);
      step();
    end
    mark = log_q.size();
    i_ready = 1'b1;
    wait_idle(10);
    check("bp_xfers", log_q.size() - mark, 2);
    check("bp_xfer_3c", count_data(mark, 8'h3C), 2);

    // Zero count then maximum count
    mark = log_q.size();
    i_valid = 1'b1; i_data = 8'h11; i_count = 4'd0;
    step();
    #1;
    check("zero_no_valid", o_valid, 0);
    i_data = 8'h22; i_count = 4'd15;
    step();
    i_valid = 1'b0;
    wait_idle(30);
    check("max_no_11", count_data(mark, 8'h11), 0);
    check("max_22_count", count_data(mark, 8'h22), 15);
    check("max_one_last", count_last(mark), 1);
    check("max_final_last", log_q[log_q.size() - 1].last, 1);

    // Clear mid-expansion after 3 transfers
    mark = log_q.size();
    i_valid = 1'b1; i_data = 8'h77; i_count = 4'd8;
    step();
    i_valid = 1'b0;
    step(); step(); step();
    check("clr_pre_rem", o_remaining, 5);
    i_clear = 1'b1;
    #1;
    check("clr_ready_low", o_ready, 0);
    step();
    i_clear = 1'b0;
    #1;
    check("clr_valid", o_valid, 0);
    check("clr_rem", o_remaining, 0);
    check("clr_ready", o_ready, 1);
    check("clr_xfers", count_data(mark, 8'h77), 3);

    // Reset mid-expansion, then a single word
    mark = log_q.size();
    i_valid = 1'b1; i_data = 8'h77; i_count = 4'd8;
    step();
    i_valid = 1'b0;
    step(); step(); step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    check("mrst_valid", o_valid, 0); check("mrst_last", o_last, 0);
    check("mrst_rem", o_remaining, 0); check("mrst_ready", o_ready, 1);
    i_valid = 1'b1; i_data = 8'h55; i_count = 4'd1;
    step();
    i_valid = 1'b0;
    check("post_valid", o_valid, 1); check("post_data", o_data, 8'h55);
    check("post_rem", o_remaining, 1); check("post_last", o_last, 1);
    step();
    check("post_done", o_valid, 0);
    step();
    check("mrst_xfers_77", count_data(mark, 8'h77), 3);
    check("mrst_xfers_55", count_data(mark, 8'h55), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
